data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_LINES, 4, number of direct-mapped lines (power of two).
- LINE_WIDTH, `MEM_DATA_WIDTH (128), line width; four 32-bit words per line.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, rising-edge clock.
- reset, in, 1, reset, synchronous, active-high.
- cpu_req, in, 1, CPU access request.
- cpu_we, in, 1, 1 = word write, 0 = word read.
- cpu_addr, in, 32, byte address; bits [1:0] ignored.
- cpu_wdata, in, 32, store data.
- cpu_ready, out, 1, cache can accept a request.
- cpu_rsp_valid, out, 1, one-cycle pulse: access complete.
- cpu_rdata, out, 32, load data, valid with cpu_rsp_valid.
- mem_req, out, 1, main-memory line request.
- mem_we, out, 1, 1 = line writeback, 0 = line fill.
- mem_addr, out, 32, line-aligned address; bits [3:0] = 0.
- mem_wdata, out, LINE_WIDTH, writeback line.
- mem_rdata, in, LINE_WIDTH, fill line.
- mem_ready, in, 1, memory completes the current mem_req this cycle.

Function
REQ-003 Address split SHALL be: offset = addr[3:2], index = addr[3+log2(NUM_LINES):4], tag = the remaining upper bits.
REQ-004 Word 0 of a line SHALL be LINE_WIDTH[127:96], and word 3 SHALL be [31:0], to match main-memory word ordering.
REQ-005 Per line, the cache SHALL hold: valid bit, dirty bit, tag, data.
REQ-006 The FSM SHALL have states IDLE, COMPARE, WRITEBACK, REFILL.
REQ-007 cpu_ready SHALL be 1 only in IDLE.
REQ-008 A request SHALL be accepted when cpu_req && cpu_ready; cpu_we, cpu_addr and cpu_wdata SHALL be registered on acceptance; the FSM SHALL then go to COMPARE.
REQ-009 COMPARE, hit (valid && tag equal):
- read: cpu_rsp_valid = 1 and cpu_rdata = the addressed word;
- write: write the addressed word, set dirty, assert cpu_rsp_valid;
- return to IDLE.
REQ-010 Hit latency SHALL be 1 cycle: the response appears in the cycle after acceptance.
REQ-011 COMPARE, miss with a valid and dirty victim SHALL go to WRITEBACK; otherwise the FSM SHALL go to REFILL.
REQ-012 WRITEBACK SHALL drive mem_req = 1, mem_we = 1, mem_addr = {victim tag, index, 4'b0}, mem_wdata = victim line.
REQ-013 WRITEBACK SHALL hold these outputs stable until mem_ready, then go to REFILL.
REQ-014 REFILL SHALL drive mem_req = 1, mem_we = 0, mem_addr = {request tag, index, 4'b0}.
REQ-015 On mem_ready in REFILL, the cache SHALL write mem_rdata into the line, set valid = 1, dirty = 0, store the tag, and go to COMPARE, which then hits.
REQ-016 mem_ready SHALL be honoured in the same cycle mem_req rises; when mem_req = 0, mem_ready SHALL be ignored.
REQ-017 In IDLE and COMPARE, mem_req SHALL be 0.
REQ-018 cpu_req arriving while cpu_ready = 0 SHALL be ignored; the CPU holds the request.
REQ-019 cpu_rdata SHALL hold its last value when cpu_rsp_valid = 0.
REQ-020 A write miss SHALL be write-allocate: refill the line, then merge the store in COMPARE.

Reset
REQ-021 On reset = 1 at a clock edge:
- state = IDLE;
- all valid and dirty bits cleared;
- cpu_rsp_valid = 0, cpu_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-022 Reset during WRITEBACK or REFILL SHALL abort the transfer; dirty data is lost, and mem_req SHALL drop in the following cycle.
REQ-023 Tag and data arrays need not be cleared by reset.

Structure
REQ-024 The shared header SHALL hold MEM_DATA_WIDTH, the line byte-offset width (4), and the FSM state encodings.
REQ-025 The valid/dirty/tag/data storage SHALL be one sub-module, cache_line_array, with a single read port and one word/line write port.
REQ-026 The FSM and datapath SHALL be in data_cache.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Cold read of 0x2000, memory returns line {A,B,C,D} after 3 cycles -> one WRITEBACK-free REFILL, mem_addr = 0x2000, cpu_rdata = A.
- Read of 0x2008 next -> no mem_req; cpu_rsp_valid in the cycle after acceptance; cpu_rdata = C.
- Write 0x1234_5678 to 0x2004, then read 0x2004 -> hit both times; read returns 0x1234_5678; dirty set.
- With 4 lines, read 0x2040 (same index as 0x2000) -> WRITEBACK first, with mem_addr = 0x2000 and mem_wdata = {A,0x12345678,C,D}; then REFILL from 0x2040.
- mem_ready already 1 when mem_req rises -> each transfer takes 1 cycle; total miss latency = 3 cycles clean, 4 cycles dirty.
- Assert reset in the 2nd cycle of REFILL -> mem_req = 0 next cycle; a re-read of 0x2000 misses.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
package data_cache_pkg;

  localparam int MEM_DATA_WIDTH = 128;
  localparam int LINE_OFFSET_W  = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } cache_state_e;

endpackage

// File: rtl/data_cache_line_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one word-or-line write port.
// Word 0 sits in the most significant slice of the line to match main-memory ordering.
module cache_line_array
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WIDTH = MEM_DATA_WIDTH,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 26
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic                  valid_o,
  output logic                  dirty_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [LINE_WIDTH-1:0] data_o,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_WIDTH-1:0] line_data_i,
  input  logic                  word_we_i,
  input  logic [1:0]            word_off_i,
  input  logic [WORD_W-1:0]     word_data_i
);

  localparam int WORDS = LINE_WIDTH / WORD_W;

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [LINE_WIDTH-1:0] data_q [NUM_LINES];
  logic [LINE_WIDTH-1:0] merged_d;

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  always_comb begin
    merged_d = data_q[idx_i];
    for (int w = 0; w < WORDS; w++) begin
      if (word_off_i == w[1:0]) merged_d[(WORDS-1-w)*WORD_W +: WORD_W] = word_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i] <= merged_d;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: hit responds 1 cycle after acceptance,
// misses write back a dirty victim then refill; cpu_ready is low whenever the FSM is busy.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rsp_valid,
  output logic [31:0]           cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - LINE_OFFSET_W - IDX_W;
  localparam int WORDS = LINE_WIDTH / WORD_W;

  cache_state_e state_q, state_d;

  logic        req_we_q;
  logic [31:2] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [31:0] rdata_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;

  logic                  arr_valid, arr_dirty;
  logic [TAG_W-1:0]      arr_tag;
  logic [LINE_WIDTH-1:0] arr_data;
  logic                  arr_line_we, arr_word_we;

  logic        hit;
  logic        accept;
  logic [31:0] hit_word;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign req_idx = req_addr_q[LINE_OFFSET_W +: IDX_W];
  assign req_tag = req_addr_q[31 -: TAG_W];
  assign req_off = req_addr_q[3:2];

  cache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WIDTH (LINE_WIDTH),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk_i       (clk),
    .reset_i     (reset),
    .idx_i       (req_idx),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .tag_o       (arr_tag),
    .data_o      (arr_data),
    .line_we_i   (arr_line_we),
    .line_tag_i  (req_tag),
    .line_data_i (mem_rdata),
    .word_we_i   (arr_word_we),
    .word_off_i  (req_off),
    .word_data_i (req_wdata_q)
  );

  assign hit    = arr_valid && (arr_tag == req_tag);
  assign accept = cpu_req && cpu_ready;

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (req_off == w[1:0]) hit_word = arr_data[(WORDS-1-w)*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cpu_req) state_d = COMPARE;
      COMPARE:   if (hit) state_d = IDLE;
                 else if (arr_valid && arr_dirty) state_d = WRITEBACK;
                 else state_d = REFILL;
      WRITEBACK: if (mem_ready) state_d = REFILL;
      REFILL:    if (mem_ready) state_d = COMPARE;
      default:   state_d = IDLE;
    endcase
  end

  // The victim line is read from the array at the request index, so it stays stable through WRITEBACK.
  always_comb begin
    cpu_ready     = 1'b0;
    cpu_rsp_valid = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    arr_word_we   = 1'b0;
    arr_line_we   = 1'b0;
    unique case (state_q)
      IDLE: cpu_ready = 1'b1;
      COMPARE: begin
        if (hit) begin
          cpu_rsp_valid = 1'b1;
          arr_word_we   = req_we_q;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {arr_tag, req_idx, {LINE_OFFSET_W{1'b0}}};
        mem_wdata = arr_data;
      end
      REFILL: begin
        mem_req     = 1'b1;
        mem_addr    = {req_tag, req_idx, {LINE_OFFSET_W{1'b0}}};
        arr_line_we = mem_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        req_we_q    <= cpu_we;
        req_addr_q  <= cpu_addr[31:2];
        req_wdata_q <= cpu_wdata;
      end
      if (cpu_rsp_valid && !req_we_q) rdata_q <= hit_word;
    end
  end

  assign cpu_rdata = (cpu_rsp_valid && !req_we_q) ? hit_word : rdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a small line-memory model answers mem_req after a chosen delay
// (or with mem_ready held high); every expected value below is hand-computed.
module tb_data_cache;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_ready, cpu_rsp_valid;
  logic [31:0]   cpu_rdata;
  logic          mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_wdata, mem_rdata;
  logic          mem_ready;

  data_cache #(.NUM_LINES(4), .LINE_WIDTH(128)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ready     (cpu_ready),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rdata     (cpu_rdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A = 32'hAAAA_0000, B = 32'hBBBB_0001, C = 32'hCCCC_0002, D = 32'hDDDD_0003;
  localparam logic [31:0] E = 32'hEEEE_0040, F = 32'hFFFF_0041, G = 32'h6666_0042, H = 32'h7777_0043;
  localparam logic [31:0] ST = 32'h1234_5678;

  int n_vec = 0;
  int n_err = 0;
  int unstable = 0;

  logic [127:0] mem_model [logic [31:0]];
  logic [31:0]  xfer_addr  [$];
  logic         xfer_we    [$];
  logic [127:0] xfer_wdata [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one access and serve memory until the response. delay = cycles mem_req stays high
  // before mem_ready (0 = same cycle); hold keeps mem_ready at 1 throughout.
  // rst_cyc > 0 asserts reset at that cycle after acceptance and returns.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic hold, input int rst_cyc,
                        output logic [31:0] rdata, output int lat);
    int           wait_cnt = 0;
    logic         in_xfer  = 1'b0;
    logic [31:0]  a0 = '0;
    logic [127:0] d0 = '0;
    xfer_addr.delete();
    xfer_we.delete();
    xfer_wdata.delete();
    lat   = -1;
    rdata = '0;
    @(negedge clk);
    check("ready_before_req", 128'(cpu_ready), 128'(1));
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_ready = hold;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_ready = hold;
      if (mem_req) begin
        if (!in_xfer) begin
          a0 = mem_addr;
          d0 = mem_wdata;
          in_xfer = 1'b1;
        end else if (mem_addr !== a0 || (mem_we && mem_wdata !== d0)) begin
          unstable++;
        end
        if (hold || wait_cnt == delay) begin
          mem_ready = 1'b1;
          xfer_addr.push_back(mem_addr);
          xfer_we.push_back(mem_we);
          xfer_wdata.push_back(mem_wdata);
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
          wait_cnt = 0;
          in_xfer  = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        reset = 1'b1;
        break;
      end
      if (cpu_rsp_valid) begin
        lat   = cyc;
        rdata = cpu_rdata;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    mem_model[32'h2000] = {A, B, C, D};
    mem_model[32'h2040] = {E, F, G, H};
    mem_model[32'h2010] = {32'h1010_0000, 32'h1010_0004, 32'h1010_0008, 32'h1010_000C};
    mem_model[32'h2030] = {32'h3030_0000, 32'h3030_0004, 32'h3030_0008, 32'h3030_000C};

    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 128'(cpu_ready), 128'(1));
    check("rst_rsp_valid", 128'(cpu_rsp_valid), 128'(0));
    check("rst_cpu_rdata", 128'(cpu_rdata), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    reset = 1'b0;

    // Cold read, memory answers on the 4th cycle of mem_req: COMPARE + 4 REFILL + COMPARE.
    access(1'b0, 32'h2000, '0, 3, 1'b0, 0, rd, lat);
    check("cold_rdata", 128'(rd), 128'(A));
    check("cold_lat", 128'(lat), 128'(6));
    check("cold_nxfer", 128'(xfer_addr.size()), 128'(1));
    if (xfer_addr.size() == 1) begin
      check("cold_addr", 128'(xfer_addr[0]), 128'(32'h2000));
      check("cold_we", 128'(xfer_we[0]), 128'(0));
    end

    access(1'b0, 32'h2008, '0, 0, 1'b0, 0, rd, lat);
    check("hit_rdata", 128'(rd), 128'(C));
    check("hit_lat", 128'(lat), 128'(1));
    check("hit_nxfer", 128'(xfer_addr.size()), 128'(0));
    @(negedge clk);
    check("rdata_held_valid", 128'(cpu_rsp_valid), 128'(0));
    check("rdata_held", 128'(cpu_rdata), 128'(C));

    access(1'b1, 32'h2004, ST, 0, 1'b0, 0, rd, lat);
    check("wr_hit_lat", 128'(lat), 128'(1));
    check("wr_hit_nxfer", 128'(xfer_addr.size()), 128'(0));
    access(1'b0, 32'h2004, '0, 0, 1'b0, 0, rd, lat);
    check("rd_after_wr", 128'(rd), 128'(ST));
    check("rd_after_wr_lat", 128'(lat), 128'(1));

    // Conflict miss on a dirty line with mem_ready held high: WB, REFILL, 4-cycle latency.
    access(1'b0, 32'h2040, '0, 0, 1'b1, 0, rd, lat);
    check("dirty_rdata", 128'(rd), 128'(E));
    check("dirty_lat", 128'(lat), 128'(4));
    check("dirty_nxfer", 128'(xfer_addr.size()), 128'(2));
    if (xfer_addr.size() == 2) begin
      check("wb_we", 128'(xfer_we[0]), 128'(1));
      check("wb_addr", 128'(xfer_addr[0]), 128'(32'h2000));
      check("wb_wdata", xfer_wdata[0], {A, ST, C, D});
      check("refill_we", 128'(xfer_we[1]), 128'(0));
      check("refill_addr", 128'(xfer_addr[1]), 128'(32'h2040));
    end

    access(1'b0, 32'h201C, '0, 0, 1'b1, 0, rd, lat);
    check("clean_rdata", 128'(rd), 128'(32'h1010_000C));
    check("clean_lat", 128'(lat), 128'(3));
    check("clean_nxfer", 128'(xfer_addr.size()), 128'(1));

    // Write miss allocates the line, then merges the store.
    access(1'b1, 32'h2034, 32'hCAFE_F00D, 0, 1'b1, 0, rd, lat);
    check("wmiss_lat", 128'(lat), 128'(3));
    check("wmiss_nxfer", 128'(xfer_addr.size()), 128'(1));
    access(1'b0, 32'h2034, '0, 0, 1'b1, 0, rd, lat);
    check("wmiss_merged", 128'(rd), 128'(32'hCAFE_F00D));
    access(1'b0, 32'h2030, '0, 0, 1'b1, 0, rd, lat);
    check("wmiss_neighbour", 128'(rd), 128'(32'h3030_0000));
    check("wmiss_neighbour_lat", 128'(lat), 128'(1));

    // Reset in the second REFILL cycle aborts the fill and clears every valid bit.
    access(1'b0, 32'h2000, '0, 20, 1'b0, 3, rd, lat);
    check("abort_nxfer", 128'(xfer_addr.size()), 128'(0));
    @(negedge clk);
    check("abort_mem_req", 128'(mem_req), 128'(0));
    check("abort_ready", 128'(cpu_ready), 128'(1));
    reset = 1'b0;
    access(1'b0, 32'h2000, '0, 0, 1'b1, 0, rd, lat);
    check("reread_lat", 128'(lat), 128'(3));
    check("reread_nxfer", 128'(xfer_addr.size()), 128'(1));
    if (xfer_addr.size() == 1) check("reread_we", 128'(xfer_we[0]), 128'(0));
    check("reread_rdata", 128'(rd), 128'(A));
    access(1'b0, 32'h2010, '0, 0, 1'b1, 0, rd, lat);
    check("other_line_lat", 128'(lat), 128'(3));

    check("mem_out_stable", 128'(unstable), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
